reply_encoder: RTL and testbench

- Reverse-direction companion to the op decoder: builds and serializes reply packets from the ASIC back to the host over the single-wire data line.
- Arbitrates three reply sources: power-on acknowledge, keyboard event, and audio-sample request (the host refills the sample stream in response).
- Each frame is: start bit, 16-bit op, optional payload, stop bit, then an idle gap. Bits advance on an externally generated bit_tick strobe.

---
 rtl/reply_encoder_pkg.sv | 21 ++
 rtl/reply_encoder_serializer.sv | 40 ++++
 rtl/reply_encoder.sv | 172 +++++++++++++++++
 tb/tb_reply_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reply_encoder_pkg.sv
// Shared constants and state encoding for the reply encoder slice.
package reply_encoder_pkg;

  localparam int unsigned MAX_FRAME_BITS = 48;
  localparam logic [5:0]  OP_BITS        = 6'd16;

  localparam logic [15:0] OP_PWR_REPLY  = 16'hC5EF;
  localparam logic [15:0] OP_KBD_EVENT  = 16'hC510;
  localparam logic [15:0] OP_AUDIO_REQ  = 16'h0700;
  localparam logic [15:0] OP_MIC_SAMPLE = 16'hC700;

  typedef enum logic [2:0] {
    IDLE,
    START,
    OP,
    PAYLOAD,
    STOP,
    GAP
  } state_t;

endpackage

// File: rtl/reply_encoder_serializer.sv
// MSB-first shift register with a down-counting bit counter; done flags the last bit of a field.
module reply_serializer
  import reply_encoder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [MAX_FRAME_BITS-1:0] load_data,
  input  logic                      tick,
  input  logic                      len_load,
  input  logic [5:0]                len,
  output logic                      msb,
  output logic                      done
);

  logic [MAX_FRAME_BITS-1:0] sreg;
  logic [5:0]                bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      if (load)
        sreg <= load_data;
      else if (tick)
        sreg <= {sreg[MAX_FRAME_BITS-2:0], 1'b0};

      // A reload on the final op bit takes precedence over the decrement.
      if (len_load)
        bit_cnt <= len - 6'd1;
      else if (tick && (bit_cnt != '0))
        bit_cnt <= bit_cnt - 6'd1;
    end
  end

  assign msb  = sreg[MAX_FRAME_BITS-1];
  assign done = (bit_cnt == '0);

endmodule

// File: rtl/reply_encoder.sv
// Arbitrates reply sources and serializes start/op/payload/stop/gap frames on tx_data.
// Optional mic-sample source is enabled with `define MIC_SAMPLE_EN.
module reply_encoder
  import reply_encoder_pkg::*;
#(
  parameter int unsigned GAP_BITS      = 4,
  parameter int unsigned KBD_PAYLOAD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_tick,
  input  logic                     pwr_req,
  output logic                     pwr_ack,
  input  logic                     kbd_valid,
  input  logic [KBD_PAYLOAD_W-1:0] kbd_data,
  output logic                     kbd_ack,
  input  logic                     audio_req,
  output logic                     audio_ack,
`ifdef MIC_SAMPLE_EN
  input  logic                     mic_valid,
  input  logic [15:0]              mic_data,
  output logic                     mic_ack,
`endif
  output logic                     tx_data,
  output logic                     busy
);

  state_t state, state_nxt;
  logic   tx_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic [5:0] pay_len, plen_nxt;

  logic grant_pwr, grant_kbd, grant_mic, grant_audio, req_any, idle_eval;
  logic [MAX_FRAME_BITS-1:0] frame;
  logic [5:0] frame_len;

  logic ser_load, ser_tick, ser_len_load, ser_msb, ser_done;
  logic [5:0] ser_len;

  // Fixed-priority arbiter: pwr > kbd > mic > audio.
  always_comb begin
    grant_pwr   = 1'b0;
    grant_kbd   = 1'b0;
    grant_mic   = 1'b0;
    grant_audio = 1'b0;
    frame       = '0;
    frame_len   = '0;
    if (pwr_req) begin
      grant_pwr     = 1'b1;
      frame[47:32]  = OP_PWR_REPLY;
    end else if (kbd_valid) begin
      grant_kbd     = 1'b1;
      frame[47:32]  = OP_KBD_EVENT;
      frame[31 -: KBD_PAYLOAD_W] = kbd_data;
      frame_len     = 6'(KBD_PAYLOAD_W);
`ifdef MIC_SAMPLE_EN
    end else if (mic_valid) begin
      grant_mic     = 1'b1;
      frame[47:32]  = OP_MIC_SAMPLE;
      frame[31:16]  = mic_data;
      frame_len     = 6'd16;
`endif
    end else if (audio_req) begin
      grant_audio   = 1'b1;
      frame[47:32]  = OP_AUDIO_REQ;
    end
    req_any = grant_pwr | grant_kbd | grant_mic | grant_audio;
  end

  assign idle_eval = (state == IDLE) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_data <= 1'b1;
      gap_cnt <= '0;
      pay_len <= '0;
    end else begin
      state   <= state_nxt;
      tx_data <= tx_nxt;
      gap_cnt <= gap_nxt;
      pay_len <= plen_nxt;
    end
  end

  // Each tick drives the next line bit; GAP's final tick coincides with the
  // last idle bit, so a pending frame's start bit follows exactly GAP_BITS idles.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_data;
    gap_nxt   = gap_cnt;
    plen_nxt  = pay_len;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          state_nxt = START;
          plen_nxt  = frame_len;
        end
      end
      START: begin
        if (bit_tick) begin
          tx_nxt    = 1'b0;
          state_nxt = OP;
        end
      end
      OP: begin
        if (bit_tick) begin
          tx_nxt = ser_msb;
          if (ser_done)
            state_nxt = (pay_len == '0) ? STOP : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (bit_tick) begin
          tx_nxt = ser_msb;
          if (ser_done)
            state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          tx_nxt    = 1'b1;
          gap_nxt   = 4'(GAP_BITS - 1);
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (bit_tick) begin
          if (gap_cnt == '0)
            state_nxt = IDLE;
          else
            gap_nxt = gap_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    pwr_ack      = idle_eval && grant_pwr;
    kbd_ack      = idle_eval && grant_kbd;
    audio_ack    = idle_eval && grant_audio;
    ser_load     = idle_eval && req_any;
    ser_tick     = bit_tick && ((state == OP) || (state == PAYLOAD));
    ser_len_load = 1'b0;
    ser_len      = OP_BITS;
    if (bit_tick && (state == START)) begin
      ser_len_load = 1'b1;
    end else if (bit_tick && (state == OP) && ser_done && (pay_len != '0)) begin
      ser_len_load = 1'b1;
      ser_len      = pay_len;
    end
  end

`ifdef MIC_SAMPLE_EN
  assign mic_ack = idle_eval && grant_mic;
`endif

  reply_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (frame),
    .tick      (ser_tick),
    .len_load  (ser_len_load),
    .len       (ser_len),
    .msb       (ser_msb),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_reply_encoder.sv
// Directed self-checking bench for reply_encoder (mic steps only when MIC_SAMPLE_EN is defined).
module tb_reply_encoder;

  localparam int unsigned GAP = 4;

  logic clk = 1'b0, rst_n = 1'b0, bit_tick = 1'b0;
  logic pwr_req = 1'b0, kbd_valid = 1'b0, audio_req = 1'b0;
  logic [31:0] kbd_data = '0;
  logic pwr_ack, kbd_ack, audio_ack, tx_data, busy;
`ifdef MIC_SAMPLE_EN
  logic mic_valid = 1'b0;
  logic [15:0] mic_data = '0;
  logic mic_ack;
  int n_mic = 0;
  logic p_mic = 1'b0;
`endif

  int vecs = 0, errs = 0;
  int n_pwr = 0, n_kbd = 0, n_audio = 0;
  logic p_pwr = 1'b0, p_kbd = 1'b0, p_audio = 1'b0;
  int tcnt = 0;

  always #5 clk = ~clk;

  reply_encoder #(.GAP_BITS(GAP), .KBD_PAYLOAD_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_tick  (bit_tick),
    .pwr_req   (pwr_req),
    .pwr_ack   (pwr_ack),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .kbd_ack   (kbd_ack),
    .audio_req (audio_req),
    .audio_ack (audio_ack),
`ifdef MIC_SAMPLE_EN
    .mic_valid (mic_valid),
    .mic_data  (mic_data),
    .mic_ack   (mic_ack),
`endif
    .tx_data   (tx_data),
    .busy      (busy)
  );

  // Bit strobe: one clk high out of every four.
  initial forever begin
    @(negedge clk);
    tcnt++;
    bit_tick = ((tcnt % 4) == 0);
  end

  // Source model: count ack pulses and withdraw a request the clk after its ack.
  initial forever begin
    @(negedge clk);
    #1;
    if (p_pwr)   pwr_req   = 1'b0;
    if (p_kbd)   kbd_valid = 1'b0;
    if (p_audio) audio_req = 1'b0;
    p_pwr = pwr_ack; p_kbd = kbd_ack; p_audio = audio_ack;
    if (pwr_ack)   n_pwr++;
    if (kbd_ack)   n_kbd++;
    if (audio_ack) n_audio++;
`ifdef MIC_SAMPLE_EN
    if (p_mic) mic_valid = 1'b0;
    p_mic = mic_ack;
    if (mic_ack) n_mic++;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bit_tick !== 1'b1 && n < 16);
    if (bit_tick !== 1'b1) begin
      vecs++;
      errs++;
      $error("FAIL %s tick timeout: observed no bit_tick, expected one within 16 clk", tag);
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp, input int unsigned nbits);
    logic [63:0] got = '0;
    int unsigned gaps = 0;
    logic gap_hi = 1'b1;
    logic busy_hi = 1'b1;
    for (int unsigned i = 0; i < nbits; i++) begin
      wait_tick(tag);
      got = {got[62:0], tx_data};
      if (busy !== 1'b1) busy_hi = 1'b0;
    end
    chk({tag, " bits"}, got, exp);
    chk({tag, " busy in frame"}, 64'(busy_hi), 64'd1);
    for (int unsigned g = 0; g < 16; g++) begin
      wait_tick(tag);
      gaps++;
      if (tx_data !== 1'b1) gap_hi = 1'b0;
      if (busy !== 1'b1) break;
    end
    chk({tag, " gap ticks"}, 64'(gaps), 64'(GAP));
    chk({tag, " gap level"}, 64'(gap_hi), 64'd1);
  endtask

  initial begin
    int n;
    logic line_hi, busy_lo;

    // Reset: line idle, nothing acked even with a request pending.
    repeat (3) @(negedge clk);
    pwr_req = 1'b1;
    #1;
    chk("reset tx", 64'(tx_data), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset pwr_ack", 64'(pwr_ack), 64'd0);

    // Power-on reply.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pwr ack pulse", 64'(pwr_ack), 64'd1);
    chk("pwr busy at latch", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("pwr ack drop", 64'(pwr_ack), 64'd0);
    chk("pwr busy rise", 64'(busy), 64'd1);
    check_frame("pwr", 64'({1'b0, 16'hC5EF, 1'b1}), 18);
    chk("pwr ack count", 64'(n_pwr), 64'd1);

    // Keyboard event; payload changes after ack must not leak into the frame.
    @(negedge clk);
    kbd_data  = 32'hDEADBEEF;
    kbd_valid = 1'b1;
    #1;
    chk("kbd ack pulse", 64'(kbd_ack), 64'd1);
    @(negedge clk);
    kbd_data = 32'h12345678;
    check_frame("kbd", 64'({1'b0, 16'hC510, 32'hDEADBEEF, 1'b1}), 50);
    chk("kbd ack count", 64'(n_kbd), 64'd1);

    // Three simultaneous requests leave in priority order.
    @(negedge clk);
    kbd_data  = 32'h0000FFFF;
    pwr_req   = 1'b1;
    kbd_valid = 1'b1;
    audio_req = 1'b1;
    #1;
    chk("chain pwr_ack", 64'(pwr_ack), 64'd1);
    chk("chain kbd_ack", 64'(kbd_ack), 64'd0);
    chk("chain audio_ack", 64'(audio_ack), 64'd0);
    check_frame("chain pwr", 64'({1'b0, 16'hC5EF, 1'b1}), 18);
    check_frame("chain kbd", 64'({1'b0, 16'hC510, 32'h0000FFFF, 1'b1}), 50);
    check_frame("chain audio", 64'({1'b0, 16'h0700, 1'b1}), 18);
    chk("chain pwr count", 64'(n_pwr), 64'd2);
    chk("chain kbd count", 64'(n_kbd), 64'd2);
    chk("chain audio count", 64'(n_audio), 64'd1);

    // Audio request arriving mid-frame waits for the gap to finish.
    @(negedge clk);
    kbd_data  = 32'hA5A55A5A;
    kbd_valid = 1'b1;
    repeat (20) wait_tick("kbd mid");
    @(negedge clk);
    audio_req = 1'b1;
    #1;
    chk("mid audio_ack held", 64'(audio_ack), 64'd0);
    chk("mid busy", 64'(busy), 64'd1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy !== 1'b0 && n < 400);
    chk("mid busy fall", 64'(busy), 64'd0);
    chk("mid audio_ack at idle", 64'(audio_ack), 64'd1);
    chk("mid audio count before", 64'(n_audio), 64'd1);
    check_frame("mid audio", 64'({1'b0, 16'h0700, 1'b1}), 18);
    chk("mid audio count after", 64'(n_audio), 64'd2);

    // Asynchronous reset inside the payload abandons the frame.
    @(negedge clk);
    kbd_data  = 32'h0;
    kbd_valid = 1'b1;
    repeat (27) wait_tick("kbd rst");
    chk("rst pre line low", 64'(tx_data), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async tx", 64'(tx_data), 64'd1);
    chk("rst async busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    line_hi = 1'b1;
    busy_lo = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx_data !== 1'b1) line_hi = 1'b0;
      if (busy !== 1'b0) busy_lo = 1'b0;
    end
    chk("post-rst line high", 64'(line_hi), 64'd1);
    chk("post-rst idle", 64'(busy_lo), 64'd1);
    chk("total kbd acks", 64'(n_kbd), 64'd4);

`ifdef MIC_SAMPLE_EN
    // Mic sample outranks the audio request.
    @(negedge clk);
    mic_data  = 16'h1234;
    mic_valid = 1'b1;
    audio_req = 1'b1;
    #1;
    chk("mic ack pulse", 64'(mic_ack), 64'd1);
    chk("mic audio held", 64'(audio_ack), 64'd0);
    check_frame("mic", 64'({1'b0, 16'hC700, 16'h1234, 1'b1}), 34);
    check_frame("mic audio", 64'({1'b0, 16'h0700, 1'b1}), 18);
    chk("mic ack count", 64'(n_mic), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
